// File: rtl/modulo_decodificador_bcd_rolhas_pkg.sv
// Shared constants and state encoding for the two-digit BCD cork-count decoder.
package modulo_decodificador_bcd_rolhas_pkg;

  localparam int DIG_W    = 4;
  localparam int NUM_ITER = 7;
  localparam int BIN_W    = NUM_ITER;
  localparam int CNT_W    = $clog2(NUM_ITER);
  localparam int BCD_MAX  = 9;
  localparam int LIMIAR   = 8;
  localparam int OFFSET   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FIM  = 2'd2
  } state_t;

  function automatic logic digito_valido(input logic [DIG_W-1:0] v);
    return v <= DIG_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/modulo_decodificador_bcd_rolhas_if.sv
// Request/result bundle between the cork-count source and the BCD decoder.
interface modulo_decodificador_bcd_rolhas_if;
  import modulo_decodificador_bcd_rolhas_pkg::*;

  logic             START;
  logic [DIG_W-1:0] BCD_D;
  logic [DIG_W-1:0] BCD_U;
  logic [BIN_W-1:0] REG_R;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (output START, BCD_D, BCD_U, input REG_R, BUSY, DONE, ERR);
  modport slave  (input START, BCD_D, BCD_U, output REG_R, BUSY, DONE, ERR);

endinterface

// File: rtl/modulo_decodificador_bcd_rolhas_ajuste.sv
// Per-digit correction step of reverse double-dabble: subtract the offset from large digits.
module modulo_ajuste_digito_bcd
  import modulo_decodificador_bcd_rolhas_pkg::*;
(
  input  logic [DIG_W-1:0] valor,
  output logic [DIG_W-1:0] ajustado
);

  assign ajustado = (valor >= DIG_W'(LIMIAR)) ? (valor - DIG_W'(OFFSET)) : valor;

endmodule

// File: rtl/modulo_decodificador_bcd_rolhas.sv
// Two-digit BCD to 7-bit binary converter using one shift/correct iteration per cycle.
//   state | meaning
//   IDLE  | waiting for START; digits sampled and validated here
//   CONV  | NUM_ITER shift/correct iterations on {D,U,B}
//   FIM   | publish result or error, pulse DONE on the following cycle
module modulo_decodificador_bcd_rolhas
  import modulo_decodificador_bcd_rolhas_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  modulo_decodificador_bcd_rolhas_if.slave bus
);

  state_t           state_q, state_d;
  logic [DIG_W-1:0] d_q, d_d;
  logic [DIG_W-1:0] u_q, u_d;
  logic [BIN_W-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inv_q, inv_d;
  logic [BIN_W-1:0] reg_r_q, reg_r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [DIG_W-1:0] d_sh, u_sh, d_adj, u_adj;
  logic [BIN_W-1:0] b_sh;

  // Whole {D,U,B} register moves right by one; digit LSBs fall into the next field.
  assign {d_sh, u_sh, b_sh} = {1'b0, d_q, u_q, b_q[BIN_W-1:1]};

  modulo_ajuste_digito_bcd u_ajuste_d (.valor(d_sh), .ajustado(d_adj));
  modulo_ajuste_digito_bcd u_ajuste_u (.valor(u_sh), .ajustado(u_adj));

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    u_d     = u_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    reg_r_d = reg_r_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          if (digito_valido(bus.BCD_D) && digito_valido(bus.BCD_U)) begin
            d_d     = bus.BCD_D;
            u_d     = bus.BCD_U;
            b_d     = '0;
            cnt_d   = '0;
            inv_d   = 1'b0;
            state_d = ST_CONV;
          end else begin
            inv_d   = 1'b1;
            state_d = ST_FIM;
          end
        end
      end
      ST_CONV: begin
        d_d   = d_adj;
        u_d   = u_adj;
        b_d   = b_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_ITER - 1)) begin
          state_d = ST_FIM;
        end
      end
      ST_FIM: begin
        done_d  = 1'b1;
        err_d   = inv_q;
        if (!inv_q) begin
          reg_r_d = b_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      u_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      reg_r_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      u_q     <= u_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      reg_r_q <= reg_r_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.REG_R = reg_r_q;
  assign bus.BUSY  = (state_q != ST_IDLE);
  assign bus.DONE  = done_q;
  assign bus.ERR   = err_q;

endmodule
